// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, fetch FSM states and PC constants for the fetch stage
package cpu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} fetch_state_t;
endpackage

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC holder and single-outstanding instruction fetcher feeding the IF/ID register
module if_fetch_unit import cpu_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            mem_stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            fetch_stall_o
);
  fetch_state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, addr_q, addr_d, instr_q, instr_d, tgt;
  logic discard_q, discard_d, adv;
  assign adv = ~stall_i & ~mem_stall_i;
  assign tgt = {branch_target_i[XLEN-1:2], 2'b00};
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    addr_d = addr_q;
    instr_d = instr_q;
    discard_d = discard_q;
    case (state_q)
      S_IDLE: begin
        if (flush_i) pc_d = tgt;
        else begin
          state_d = S_WAIT;
          addr_d = pc_q;
        end
      end
      S_WAIT: begin
        if (flush_i) pc_d = tgt;
        // the request stays on addr_q until acked; a redirect only marks its data stale
        if (imem_ack_i) begin
          discard_d = 1'b0;
          instr_d = imem_rdata_i;
          state_d = (discard_q | flush_i) ? S_IDLE : S_HOLD;
        end else if (flush_i) discard_d = 1'b1;
      end
      S_HOLD: begin
        if (flush_i) begin
          pc_d = tgt;
          state_d = S_IDLE;
        end else if (adv) begin
          pc_d = pc_q + PC_STEP;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      pc_q <= RESET_PC;
      addr_q <= RESET_PC;
      instr_q <= NOP_INSTR;
      discard_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      addr_q <= addr_d;
      instr_q <= instr_d;
      discard_q <= discard_d;
    end
  end
  assign imem_req_o = state_q == S_WAIT;
  assign imem_addr_o = addr_q;
  assign fetch_stall_o = state_q != S_HOLD;
  assign instr_o = fetch_stall_o ? NOP_INSTR : instr_q;
  assign pc_o = fetch_stall_o ? '0 : pc_q;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: randomized fetch traffic checked against a transaction-level fetch model
module tb_if_fetch_unit;
  logic clk_i = 1'b0;
  logic rst_i, stall_i, mem_stall_i, flush_i, imem_ack_i;
  logic [31:0] branch_target_i, imem_rdata_i;
  logic imem_req_o, fetch_stall_o;
  logic [31:0] imem_addr_o, instr_o, pc_o;
  int compared = 0, mismatched = 0;
  bit m_valid, m_busy, m_drop;
  logic [31:0] m_pc, m_addr, m_instr;
  bit pend;
  int dly, maxd;
  if_fetch_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .mem_stall_i(mem_stall_i),
    .flush_i(flush_i), .branch_target_i(branch_target_i), .imem_req_o(imem_req_o),
    .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .instr_o(instr_o), .pc_o(pc_o), .fetch_stall_o(fetch_stall_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input bit r, input bit st, input bit ms, input bit fl, input logic [31:0] tg);
    @(negedge clk_i);
    chk("imem_req", {31'b0, imem_req_o}, {31'b0, m_busy});
    if (m_busy) chk("imem_addr", imem_addr_o, m_addr);
    chk("instr", instr_o, m_valid ? m_instr : 32'h0);
    chk("pc", pc_o, m_valid ? m_pc : 32'h0);
    chk("fetch_stall", {31'b0, fetch_stall_o}, {31'b0, !m_valid});
    rst_i = r;
    stall_i = st;
    mem_stall_i = ms;
    flush_i = fl;
    branch_target_i = tg;
    // memory model: one response per observed request, delayed 0..maxd cycles, survives reset
    imem_ack_i = 1'b0;
    if (imem_req_o && !pend) begin
      pend = 1;
      dly = $urandom_range(maxd, 0);
    end
    if (pend) begin
      if (dly == 0) begin
        imem_ack_i = 1'b1;
        pend = 0;
      end else dly--;
    end
    imem_rdata_i = imem_ack_i ? mem(imem_addr_o) : $urandom;
    if (!r) begin
      m_pc = 32'h0; m_valid = 0; m_busy = 0; m_drop = 0;
    end else if (m_busy) begin
      if (imem_ack_i) begin
        m_busy = 0;
        if (!m_drop && !fl) begin
          m_valid = 1;
          m_instr = mem(m_addr);
        end
        m_drop = 0;
      end else if (fl) m_drop = 1;
      if (fl) m_pc = tg & ~32'h3;
    end else if (m_valid) begin
      if (fl) begin
        m_valid = 0;
        m_pc = tg & ~32'h3;
      end else if (!st && !ms) begin
        m_valid = 0;
        m_pc = m_pc + 32'd4;
      end
    end else if (fl) m_pc = tg & ~32'h3;
    else begin
      m_busy = 1;
      m_addr = m_pc;
    end
  endtask
  task automatic run(input int n, input int ps, input int pf, input int pr, input int md);
    maxd = md;
    for (int i = 0; i < n; i++)
      step(($urandom_range(999, 0) >= pr), ($urandom_range(99, 0) < ps), ($urandom_range(99, 0) < ps),
           ($urandom_range(99, 0) < pf), ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15, 0)) : $urandom);
  endtask
  initial begin
    rst_i = 1'b0; stall_i = 1'b0; mem_stall_i = 1'b0; flush_i = 1'b0;
    branch_target_i = '0; imem_ack_i = 1'b0; imem_rdata_i = '0;
    pend = 0; dly = 0; maxd = 0;
    repeat (2) @(posedge clk_i);
    m_pc = 32'h0; m_valid = 0; m_busy = 0; m_drop = 0; m_addr = '0; m_instr = '0;
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, '0);
    step(1, 0, 0, 1, 32'hFFFF_FFFB);
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0, '0);
    maxd = 3;
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0, '0);
    step(1, 1, 1, 1, 32'h23);
    step(1, 0, 0, 1, 32'h100);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, '0);
    run(800, 10, 5, 5, 0);
    run(800, 30, 10, 5, 3);
    run(800, 50, 25, 20, 2);
    run(800, 5, 2, 2, 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
